// File: rtl/bfm_apbtoahb_pkg.sv
// Shared types and bus constants for the APB3-to-AHB-Lite bridge.
package bfm_apbtoahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // APB address to word-aligned AHB address.
  function automatic logic [31:0] map_addr(input logic [31:0] paddr,
                                           input logic [31:0] mask,
                                           input logic [31:0] base);
    logic [31:0] a;
    a      = (paddr & mask) | base;
    a[1:0] = 2'b00;
    return a;
  endfunction

endpackage

// File: rtl/bfm_apbtoahb_if.sv
// APB3 completer side and AHB-Lite manager side of the bridge in one bundle.
interface bfm_apbtoahb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  // Bridge side.
  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, HRDATA, HREADY, HRESP,
    output PRDATA, PREADY, PSLVERR, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
    output HMASTLOCK, HPROT, HWDATA
  );

  // Environment side: APB requester plus AHB slave.
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, HRDATA, HREADY, HRESP,
    input  PRDATA, PREADY, PSLVERR, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
    input  HMASTLOCK, HPROT, HWDATA
  );
endinterface

// File: rtl/bfm_apbtoahb.sv
// APB3 completer to AHB-Lite manager: one single word transfer per APB access,
// APB access phase stretched with PREADY until the AHB data phase completes.
module bfm_apbtoahb
  import bfm_apbtoahb_pkg::*;
#(
  parameter int          TPD       = 1,
  parameter logic [31:0] ADDR_MASK = 32'h0FFF_FFFF,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input logic           HCLK,
  input logic           HRESET,
  bfm_apbtoahb_if.slave bus
);

  state_t      r_state;
  logic [31:0] r_haddr;
  logic [1:0]  r_htrans;
  logic        r_hwrite;
  logic [31:0] r_hwdata;
  logic [31:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= ST_IDLE;
      r_haddr   <= '0;
      r_htrans  <= HTRANS_IDLE;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            r_haddr  <= map_addr(bus.PADDR, ADDR_MASK, ADDR_BASE);
            r_hwrite <= bus.PWRITE;
            r_hwdata <= bus.PWDATA;
            r_htrans <= HTRANS_NONSEQ;
            r_state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.HREADY) begin
            r_htrans <= HTRANS_IDLE;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          // The first cycle of a two-cycle ERROR has HREADY=0 and is just a wait.
          if (bus.HREADY) begin
            if (!r_hwrite && !bus.HRESP) r_prdata <= bus.HRDATA;
            r_pready  <= 1'b1;
            r_pslverr <= bus.HRESP;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.HADDR     = r_haddr;
  assign bus.HTRANS    = r_htrans;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HWDATA    = r_hwdata;
  assign bus.PRDATA    = r_prdata;
  assign bus.PREADY    = r_pready;
  assign bus.PSLVERR   = r_pslverr;
  assign bus.HSIZE     = HSIZE_WORD;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_bfm_apbtoahb.sv
// Bench for bfm_apbtoahb: directed vector table, random transfers and a reset-in-DATA sequence.
module tb_bfm_apbtoahb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] model_prdata = 32'h0;

  bfm_apbtoahb_if bus();

  bfm_apbtoahb dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] exp_haddr;
    int          exp_lat;
    bit          idle_after;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address map and latency stated as plain arithmetic on the default parameters.
  function automatic logic [31:0] ref_haddr(input logic [31:0] a);
    return ((a % 32'h1000_0000) / 4) * 4;
  endfunction

  function automatic int ref_lat(input int aw, input int dw);
    return 3 + aw + dw;
  endfunction

  // Caller must be positioned just after a rising edge. Returns at the
  // falling edge of the PREADY cycle.
  task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int aw, input int dw, input bit err,
                          input logic [31:0] rd, input logic [31:0] xhaddr, input int xlat);
    logic [1:0] exp_tr;
    bit         rdy;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = w;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    bus.HREADY  = 1'b1;
    bus.HRESP   = 1'b0;
    bus.HRDATA  = ~rd;
    @(negedge clk);
    chk("setup_pready", 32'(bus.PREADY), 32'h0);
    chk("setup_htrans", 32'(bus.HTRANS), 32'h0);
    for (int cyc = 1; cyc <= xlat; cyc++) begin
      step();
      bus.PENABLE = 1'b1;
      bus.HRDATA  = ~rd;
      bus.HRESP   = 1'b0;
      if (cyc <= aw) bus.HREADY = 1'b0;
      else if (cyc == aw + 1) bus.HREADY = 1'b1;
      else if (cyc <= aw + 1 + dw) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = err && (cyc == aw + 1 + dw);
      end else if (cyc == aw + 2 + dw) begin
        bus.HREADY = 1'b1;
        bus.HRESP  = err;
        bus.HRDATA = rd;
      end else begin
        bus.HREADY = 1'b1;
      end
      @(negedge clk);
      exp_tr = (cyc <= aw + 1) ? 2'b10 : 2'b00;
      rdy    = (cyc == xlat);
      chk("htrans", 32'(bus.HTRANS), 32'(exp_tr));
      chk("pready", 32'(bus.PREADY), 32'(rdy));
      chk("pslverr", 32'(bus.PSLVERR), 32'(rdy && err));
      if (cyc <= aw + 1) begin
        chk("haddr", bus.HADDR, xhaddr);
        chk("hwrite", 32'(bus.HWRITE), 32'(w));
      end
      if (w && cyc < xlat) chk("hwdata", bus.HWDATA, d);
      if (rdy) begin
        if (!w && !err) model_prdata = rd;
        chk("prdata", bus.PRDATA, model_prdata);
      end
    end
  endtask

  task automatic idle_cycle();
    step();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.HREADY  = 1'b1;
    bus.HRESP   = 1'b0;
    @(negedge clk);
    chk("idle_pready", 32'(bus.PREADY), 32'h0);
    chk("idle_pslverr", 32'(bus.PSLVERR), 32'h0);
    chk("idle_htrans", 32'(bus.HTRANS), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0,         32'h0000_0004, 3, 1'b1};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         0, 2, 1'b0, 32'h1234_5678, 32'h0000_0010, 5, 1'b1};
    vecs[2] = '{1'b0, 32'h2000_0020, 32'h0,         3, 0, 1'b0, 32'hA5A5_A5A5, 32'h0000_0020, 6, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,         0, 1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0030, 4, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0008, 32'h1111_2222, 0, 0, 1'b0, 32'h0,         32'h0000_0008, 3, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_000C, 32'h0,         0, 0, 1'b0, 32'hCAFE_F00D, 32'h0000_000C, 3, 1'b1};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1, 1, 1'b0, 32'h0,         32'h0FFF_FFFC, 5, 1'b1};

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.HRDATA = '0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    #1;
    chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_prdata", bus.PRDATA, 32'h0);
    chk("rst_pready", 32'(bus.PREADY), 32'h0);
    chk("rst_pslverr", 32'(bus.PSLVERR), 32'h0);
    chk("hsize", 32'(bus.HSIZE), 32'h2);
    chk("hburst", 32'(bus.HBURST), 32'h0);
    chk("hmastlock", 32'(bus.HMASTLOCK), 32'h0);
    chk("hprot", 32'(bus.HPROT), 32'h3);
    step();
    step();
    rst = 1'b0;

    foreach (vecs[i]) begin
      step();
      run_xfer(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].aw, vecs[i].dw,
               vecs[i].err, vecs[i].rdata, vecs[i].exp_haddr, vecs[i].exp_lat);
      if (vecs[i].idle_after) idle_cycle();
    end

    for (int k = 0; k < 24; k++) begin
      logic        w;
      logic [31:0] a, d, rd;
      int          aw, dw;
      bit          err;
      w   = 1'($urandom);
      a   = $urandom;
      d   = $urandom;
      rd  = $urandom;
      aw  = int'($urandom_range(0, 2));
      dw  = int'($urandom_range(0, 3));
      err = (dw > 0) && ($urandom_range(0, 3) == 0);
      step();
      run_xfer(w, a, d, aw, dw, err, rd, ref_haddr(a), ref_lat(aw, dw));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Reset asserted while the bridge waits in the data phase of a write.
    step();
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h0000_0040; bus.PWDATA = 32'h55AA_55AA; bus.HREADY = 1'b1;
    step();
    bus.PENABLE = 1'b1;
    step();
    bus.HREADY = 1'b0;
    @(negedge clk);
    chk("pre_rst_haddr", bus.HADDR, 32'h0000_0040);
    #2;
    rst = 1'b1;
    #1;
    model_prdata = 32'h0;
    chk("arst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("arst_haddr", bus.HADDR, 32'h0);
    chk("arst_hwrite", 32'(bus.HWRITE), 32'h0);
    chk("arst_hwdata", bus.HWDATA, 32'h0);
    chk("arst_prdata", bus.PRDATA, 32'h0);
    chk("arst_pready", 32'(bus.PREADY), 32'h0);
    chk("arst_pslverr", 32'(bus.PSLVERR), 32'h0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.HREADY = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle_cycle();
    step();
    run_xfer(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 0, 0, 1'b0, 32'h0, 32'h0000_0044, 3);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
